// File: rtl/rs232_pkg.sv
// Shared definitions for the RS-232 transmit/receive blocks: state encoding,
// parity modes and line idle level.
package rs232_pkg;

   typedef enum logic [4:0] {
      ST_IDLE   = 5'b00001,
      ST_START  = 5'b00010,
      ST_DATA   = 5'b00100,
      ST_PARITY = 5'b01000,
      ST_STOP   = 5'b10000
   } tx_state_t;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_EVEN = 1;
   localparam int PARITY_ODD  = 2;

   localparam logic TXD_IDLE = 1'b1;

   // Even parity is the XOR of the data bits; odd parity is its complement.
   function automatic logic parity_bit(input logic [7:0] data, input int mode);
      return (^data) ^ (mode == PARITY_ODD);
   endfunction

endpackage

// File: rtl/rs232_baud_tick.sv
// Bit-period timer: counts CLKS_PER_BIT cycles while enabled and pulses bit_end
// on the last cycle of each bit. Shared by the transmitter and receiver.
module rs232_baud_tick #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic reset_n,
   input  logic enable,
   input  logic restart,
   output logic bit_end
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt_reg;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_reg <= '0;
      end else if (restart || !enable || cnt_reg == LAST) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_reg + CW'(1);
      end
   end

   assign bit_end = enable && (cnt_reg == LAST);

endmodule

// File: rtl/rs232_tx_engine.sv
// RS-232 transmitter: one-byte holding buffer behind a valid/ready handshake,
// framing start, 8 data bits LSB first, optional parity and 1 or 2 stop bits.
module rs232_tx_engine
   import rs232_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int PARITY_MODE  = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       txd,
   output logic       tx_busy
);

   localparam logic STOP_LAST = 1'(STOP_BITS - 1);

   tx_state_t  state_reg, state_next;
   logic [7:0] shift_reg, shift_next;
   logic [7:0] buf_reg, buf_next;
   logic       buf_full_reg, buf_full_next;
   logic       parity_reg, parity_next;
   logic [2:0] bit_cnt_reg, bit_cnt_next;
   logic       stop_cnt_reg, stop_cnt_next;
   logic       txd_reg, txd_next;
   logic       tx_ready_reg;
   logic       tx_busy_reg;
   logic       load;
   logic       bit_end;

   rs232_baud_tick #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk    (clk),
      .reset_n(reset_n),
      .enable (state_reg != ST_IDLE),
      .restart(load),
      .bit_end(bit_end)
   );

   always_comb begin
      state_next    = state_reg;
      shift_next    = shift_reg;
      buf_next      = buf_reg;
      buf_full_next = buf_full_reg;
      parity_next   = parity_reg;
      bit_cnt_next  = bit_cnt_reg;
      stop_cnt_next = stop_cnt_reg;
      txd_next      = txd_reg;
      load          = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            txd_next = TXD_IDLE;
            if (buf_full_reg) load = 1'b1;
         end
         ST_START: begin
            if (bit_end) begin
               state_next   = ST_DATA;
               txd_next     = shift_reg[0];
               bit_cnt_next = '0;
            end
         end
         ST_DATA: begin
            if (bit_end) begin
               if (bit_cnt_reg == 3'd7) begin
                  if (PARITY_MODE != PARITY_NONE) begin
                     state_next = ST_PARITY;
                     txd_next   = parity_reg;
                  end else begin
                     state_next    = ST_STOP;
                     txd_next      = TXD_IDLE;
                     stop_cnt_next = 1'b0;
                  end
               end else begin
                  shift_next   = {1'b0, shift_reg[7:1]};
                  txd_next     = shift_reg[1];
                  bit_cnt_next = bit_cnt_reg + 3'd1;
               end
            end
         end
         ST_PARITY: begin
            if (bit_end) begin
               state_next    = ST_STOP;
               txd_next      = TXD_IDLE;
               stop_cnt_next = 1'b0;
            end
         end
         ST_STOP: begin
            if (bit_end) begin
               if (stop_cnt_reg == STOP_LAST) begin
                  // A waiting byte starts its frame with no idle gap.
                  if (buf_full_reg) load = 1'b1;
                  else state_next = ST_IDLE;
               end else begin
                  stop_cnt_next = stop_cnt_reg + 1'b1;
               end
            end
         end
         default: begin
            state_next = ST_IDLE;
            txd_next   = TXD_IDLE;
         end
      endcase

      if (load) begin
         state_next    = ST_START;
         shift_next    = buf_reg;
         parity_next   = parity_bit(buf_reg, PARITY_MODE);
         buf_full_next = 1'b0;
         txd_next      = 1'b0;
      end

      // Ready is low whenever the buffer is full, so this never collides with a load.
      if (tx_valid && tx_ready_reg) begin
         buf_next      = tx_data;
         buf_full_next = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg    <= ST_IDLE;
         shift_reg    <= '0;
         buf_reg      <= '0;
         buf_full_reg <= 1'b0;
         parity_reg   <= 1'b0;
         bit_cnt_reg  <= '0;
         stop_cnt_reg <= 1'b0;
         txd_reg      <= TXD_IDLE;
         tx_ready_reg <= 1'b0;
         tx_busy_reg  <= 1'b0;
      end else begin
         state_reg    <= state_next;
         shift_reg    <= shift_next;
         buf_reg      <= buf_next;
         buf_full_reg <= buf_full_next;
         parity_reg   <= parity_next;
         bit_cnt_reg  <= bit_cnt_next;
         stop_cnt_reg <= stop_cnt_next;
         txd_reg      <= txd_next;
         tx_ready_reg <= !buf_full_next;
         tx_busy_reg  <= (state_next != ST_IDLE) || buf_full_next;
      end
   end

   assign tx_ready = tx_ready_reg;
   assign txd      = txd_reg;
   assign tx_busy  = tx_busy_reg;

endmodule

// File: tb/tb_rs232_tx_engine.sv
// Self-checking bench for rs232_tx_engine: three instances (no parity, even
// parity, odd parity with 2 stop bits) compared against a frame-level model.
module tb_rs232_tx_engine;

   localparam int CLKS = 4;
   localparam int PM[3] = '{0, 1, 2};
   localparam int SB[3] = '{1, 1, 2};

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [7:0] data_s  [3];
   logic       valid_s [3];
   logic       ready_s [3];
   logic       txd_s   [3];
   logic       busy_s  [3];

   int tests_run = 0;
   int tests_failed = 0;
   int cyc = 0;

   // Capture of the most recent stream, indexed by (cycle - cap_base).
   logic cap_txd[$];
   logic cap_rdy[$];
   int   cap_base;
   int   hs_edge[4];
   int   hs_n;
   int   first_low;
   int   busy_fall;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   rs232_tx_engine #(.CLKS_PER_BIT(CLKS), .PARITY_MODE(0), .STOP_BITS(1)) u_dut0 (
      .clk(clk), .reset_n(reset_n), .tx_data(data_s[0]), .tx_valid(valid_s[0]),
      .tx_ready(ready_s[0]), .txd(txd_s[0]), .tx_busy(busy_s[0]));
   rs232_tx_engine #(.CLKS_PER_BIT(CLKS), .PARITY_MODE(1), .STOP_BITS(1)) u_dut1 (
      .clk(clk), .reset_n(reset_n), .tx_data(data_s[1]), .tx_valid(valid_s[1]),
      .tx_ready(ready_s[1]), .txd(txd_s[1]), .tx_busy(busy_s[1]));
   rs232_tx_engine #(.CLKS_PER_BIT(CLKS), .PARITY_MODE(2), .STOP_BITS(2)) u_dut2 (
      .clk(clk), .reset_n(reset_n), .tx_data(data_s[2]), .tx_valid(valid_s[2]),
      .tx_ready(ready_s[2]), .txd(txd_s[2]), .tx_busy(busy_s[2]));

   function automatic int frame_len(input int d);
      return (9 + ((PM[d] != 0) ? 1 : 0) + SB[d]) * CLKS;
   endfunction

   // Line level k cycles into a frame carrying v.
   function automatic logic model_bit(input int d, input logic [7:0] v, input int k);
      int idx;
      idx = k / CLKS;
      if (idx == 0) return 1'b0;
      if (idx <= 8) return v[idx-1];
      if (PM[d] != 0 && idx == 9) return (PM[d] == 1) ? ^v : ~^v;
      return 1'b1;
   endfunction

   // Frames are back to back from cycle 'start'; idle high elsewhere.
   // Returns the first capture index that disagrees, or -1.
   function automatic int wave_diff(input int d, input int n, input logic [7:0] b0,
                                    input logic [7:0] b1, input logic [7:0] b2, input int start);
      logic [7:0] bq[3];
      int fl;
      bq[0] = b0; bq[1] = b1; bq[2] = b2;
      fl = frame_len(d);
      for (int k = 0; k < cap_txd.size(); k++) begin
         int   off;
         logic want;
         off = cap_base + k - start;
         if (off < 0 || off >= n * fl) want = 1'b1;
         else want = model_bit(d, bq[off / fl], off % fl);
         if (cap_txd[k] !== want) return k;
      end
      return -1;
   endfunction

   task automatic drive(input int d, input logic v, input logic [7:0] x);
      valid_s[d] = v;
      data_s[d]  = x;
   endtask

   // Offers n bytes with tx_valid held high, recording line, ready, handshakes.
   task automatic run_stream(input int d, input int n, input logic [7:0] b0,
                             input logic [7:0] b1, input logic [7:0] b2);
      logic [7:0] bq[3];
      logic pr;
      int   fl;
      bq[0] = b0; bq[1] = b1; bq[2] = b2;
      fl = frame_len(d);
      cap_txd.delete();
      cap_rdy.delete();
      hs_n = 0; first_low = -1; busy_fall = -1;
      @(negedge clk);
      drive(d, 1'b1, bq[0]);
      pr = ready_s[d];
      cap_base = cyc + 1;
      for (int c = 0; c < n * fl + 20; c++) begin
         @(negedge clk);
         if (valid_s[d] && pr && hs_n < 4) begin
            hs_edge[hs_n] = cyc;
            $display("[TB] dut%0d accepted byte %0d = 0x%02h at edge %0d", d, hs_n, data_s[d], cyc);
            hs_n++;
            if (hs_n < n) drive(d, 1'b1, bq[hs_n]);
            else drive(d, 1'b0, 8'h00);
         end
         pr = ready_s[d];
         cap_txd.push_back(txd_s[d]);
         cap_rdy.push_back(pr);
         if (first_low < 0 && txd_s[d] == 1'b0) first_low = cyc;
         if (first_low >= 0 && busy_fall < 0 && !busy_s[d]) busy_fall = cyc;
      end
      drive(d, 1'b0, 8'h00);
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         tests_run++;
         if (txd_s[d] !== 1'b1 || ready_s[d] !== 1'b0 || busy_s[d] !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_values dut%0d: txd/ready/busy=%b%b%b required 100", d, txd_s[d], ready_s[d], busy_s[d]);
         end
      end
      reset_n = 1'b1;
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         tests_run++;
         if (ready_s[d] !== 1'b1 || txd_s[d] !== 1'b1 || busy_s[d] !== 1'b0) begin
            tests_failed++;
            $display("FAIL ready_after_reset dut%0d: txd/ready/busy=%b%b%b required 110", d, txd_s[d], ready_s[d], busy_s[d]);
         end
      end
   endtask

   task automatic test_single_byte;
      int diff;
      run_stream(0, 1, 8'hA5, 8'h00, 8'h00);
      tests_run++;
      if (hs_n !== 1 || hs_edge[0] !== cap_base) begin
         tests_failed++;
         $display("FAIL single_handshake: count=%0d edge=%0d required 1 at %0d", hs_n, hs_edge[0], cap_base);
      end
      tests_run++;
      if (first_low !== cap_base + 1) begin
         tests_failed++;
         $display("FAIL single_start_latency: start at %0d required %0d", first_low, cap_base + 1);
      end
      diff = wave_diff(0, 1, 8'hA5, 8'h00, 8'h00, cap_base + 1);
      tests_run++;
      if (diff !== -1) begin
         tests_failed++;
         $display("FAIL single_waveform: first wrong line level at capture index %0d, required none", diff);
      end
      tests_run++;
      if (busy_fall !== cap_base + 41) begin
         tests_failed++;
         $display("FAIL single_busy_fall: fell at %0d required %0d", busy_fall, cap_base + 41);
      end
   endtask

   task automatic test_back_to_back;
      int diff;
      run_stream(0, 2, 8'h00, 8'hFF, 8'h00);
      tests_run++;
      if (hs_n !== 2 || hs_edge[1] !== cap_base + 2) begin
         tests_failed++;
         $display("FAIL b2b_second_handshake: count=%0d edge=%0d required 2 at %0d", hs_n, hs_edge[1], cap_base + 2);
      end
      tests_run++;
      if (cap_txd[40] !== 1'b1 || cap_txd[41] !== 1'b0) begin
         tests_failed++;
         $display("FAIL b2b_no_gap: stop/start levels=%b%b required 10", cap_txd[40], cap_txd[41]);
      end
      diff = wave_diff(0, 2, 8'h00, 8'hFF, 8'h00, cap_base + 1);
      tests_run++;
      if (diff !== -1) begin
         tests_failed++;
         $display("FAIL b2b_waveform: first wrong line level at capture index %0d, required none", diff);
      end
      tests_run++;
      if (busy_fall !== cap_base + 81) begin
         tests_failed++;
         $display("FAIL b2b_busy_fall: fell at %0d required %0d", busy_fall, cap_base + 81);
      end
   endtask

   task automatic test_parity;
      int diff;
      int ones;
      run_stream(1, 1, 8'h07, 8'h00, 8'h00);
      tests_run++;
      if (cap_txd[37] !== 1'b1) begin
         tests_failed++;
         $display("FAIL parity_even_0x07: bit=%b required 1", cap_txd[37]);
      end
      diff = wave_diff(1, 1, 8'h07, 8'h00, 8'h00, cap_base + 1);
      tests_run++;
      if (diff !== -1 || busy_fall !== cap_base + 45) begin
         tests_failed++;
         $display("FAIL parity_even_frame: diff=%0d busy_fall=%0d required -1 and %0d", diff, busy_fall, cap_base + 45);
      end
      run_stream(2, 2, 8'h07, 8'h07, 8'h00);
      tests_run++;
      if (cap_txd[37] !== 1'b0) begin
         tests_failed++;
         $display("FAIL parity_odd_0x07: bit=%b required 0", cap_txd[37]);
      end
      ones = 0;
      for (int k = 41; k <= 48; k++) if (cap_txd[k] === 1'b1) ones++;
      tests_run++;
      if (ones !== 8 || cap_txd[49] !== 1'b0) begin
         tests_failed++;
         $display("FAIL two_stop_bits: stop cycles high=%0d next start=%b required 8 and 0", ones, cap_txd[49]);
      end
      diff = wave_diff(2, 2, 8'h07, 8'h07, 8'h00, cap_base + 1);
      tests_run++;
      if (diff !== -1) begin
         tests_failed++;
         $display("FAIL parity_odd_waveform: first wrong line level at capture index %0d, required none", diff);
      end
   endtask

   task automatic test_backpressure;
      logic [7:0] b0, b1, b2;
      int diff;
      int early;
      b0 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom);
      run_stream(0, 3, b0, b1, b2);
      tests_run++;
      if (hs_n !== 3 || hs_edge[2] !== cap_base + 42) begin
         tests_failed++;
         $display("FAIL backpressure_third_handshake: count=%0d edge=%0d required 3 at %0d", hs_n, hs_edge[2], cap_base + 42);
      end
      early = 0;
      for (int k = 2; k <= 40; k++) if (cap_rdy[k] !== 1'b0) early++;
      tests_run++;
      if (early !== 0 || cap_rdy[41] !== 1'b1) begin
         tests_failed++;
         $display("FAIL backpressure_ready: high-while-full cycles=%0d ready at drain=%b required 0 and 1", early, cap_rdy[41]);
      end
      diff = wave_diff(0, 3, b0, b1, b2, cap_base + 1);
      tests_run++;
      if (diff !== -1) begin
         tests_failed++;
         $display("FAIL backpressure_order: first wrong line level at capture index %0d, required none (bytes %02h %02h %02h)", diff, b0, b1, b2);
      end
   endtask

   task automatic test_reset_mid_frame;
      int base;
      int bad;
      @(negedge clk);
      drive(0, 1'b1, 8'hA5);
      base = cyc + 1;
      @(negedge clk);
      drive(0, 1'b1, 8'h3C);
      repeat (2) @(negedge clk);
      drive(0, 1'b0, 8'h00);
      while (cyc < base + 18) @(negedge clk);
      tests_run++;
      if (txd_s[0] !== 1'b0 || ready_s[0] !== 1'b0) begin
         tests_failed++;
         $display("FAIL mid_frame_bit3: txd/ready=%b%b required 00", txd_s[0], ready_s[0]);
      end
      #2 reset_n = 1'b0;
      #1;
      tests_run++;
      if (txd_s[0] !== 1'b1 || ready_s[0] !== 1'b0 || busy_s[0] !== 1'b0) begin
         tests_failed++;
         $display("FAIL async_reset: txd/ready/busy=%b%b%b required 100", txd_s[0], ready_s[0], busy_s[0]);
      end
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      tests_run++;
      if (ready_s[0] !== 1'b1) begin
         tests_failed++;
         $display("FAIL ready_after_release: ready=%b required 1", ready_s[0]);
      end
      bad = 0;
      repeat (60) begin
         @(negedge clk);
         if (txd_s[0] !== 1'b1 || busy_s[0] !== 1'b0) bad++;
      end
      tests_run++;
      if (bad !== 0) begin
         tests_failed++;
         $display("FAIL no_residual_frame: active cycles=%0d required 0", bad);
      end
   endtask

   task automatic test_random;
      for (int it = 0; it < 10; it++) begin
         int d, n, diff;
         logic [7:0] b0, b1, b2;
         d = $urandom_range(0, 2);
         n = $urandom_range(1, 3);
         b0 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom);
         run_stream(d, n, b0, b1, b2);
         diff = wave_diff(d, n, b0, b1, b2, cap_base + 1);
         tests_run++;
         if (hs_n !== n || diff !== -1) begin
            tests_failed++;
            $display("FAIL random_stream it%0d dut%0d: handshakes=%0d diff=%0d required %0d and -1", it, d, hs_n, diff, n);
         end
         tests_run++;
         if (busy_fall !== cap_base + 1 + n * frame_len(d)) begin
            tests_failed++;
            $display("FAIL random_busy_fall it%0d dut%0d: fell at %0d required %0d", it, d, busy_fall, cap_base + 1 + n * frame_len(d));
         end
         repeat ($urandom_range(0, 5)) @(negedge clk);
      end
   endtask

   initial begin
      for (int d = 0; d < 3; d++) drive(d, 1'b0, 8'h00);
      test_reset();
      test_single_byte();
      test_back_to_back();
      test_parity();
      test_backpressure();
      test_reset_mid_frame();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached before completion");
      $fatal(1, "timeout");
   end

endmodule
